// File: rtl/noise_test_top.sv
// Noise-test stimulus generator: a start edge launches a fixed-length LFSR bit burst on pin_1,
// and a 4-digit BCD count of completed bursts drives four seven-segment displays. Option macro: DIFF_OUT_EN.
module noise_test_top #(
  parameter int          BIT_DIV   = 5,
  parameter int          BURST_LEN = 32,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       pin_1,
  output logic       pin_2,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3
);

  localparam int DIV_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam int LEN_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);
  localparam logic [LEN_W-1:0] LEN_LAST = LEN_W'(BURST_LEN - 1);
  localparam logic [6:0] SEG_ZERO = 7'b1000000;

  typedef enum logic {IDLE, BURST} state_t;

  state_t state, state_next;

  logic sync_1, sync_2, sync_prev;
  logic start_edge;
  logic [15:0] lfsr, lfsr_next;
  logic [DIV_W-1:0] div_cnt;
  logic [LEN_W-1:0] bit_cnt;
  logic bit_end, burst_end;
  logic launch, finish;
  logic marker;
  logic [3:0][3:0] bcd, bcd_inc;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // Two-flop synchronizer plus a third flop remembering the previous synchronized level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_1    <= 1'b0;
      sync_2    <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync_1    <= start;
      sync_2    <= sync_1;
      sync_prev <= sync_2;
    end
  end

  assign start_edge = sync_2 & ~sync_prev;
  assign lfsr_next  = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  assign bit_end    = (div_cnt == DIV_LAST);
  assign burst_end  = bit_end && (bit_cnt == LEN_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    launch     = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start_edge) begin
          state_next = BURST;
          launch     = 1'b1;
        end
      end
      BURST: begin
        if (burst_end) begin
          state_next = IDLE;
          finish     = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Ripple-carry BCD increment; 9999 rolls over to 0000.
  always_comb begin
    logic carry;
    bcd_inc = bcd;
    carry   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (bcd[i] == 4'd9) begin
          bcd_inc[i] = 4'd0;
        end else begin
          bcd_inc[i] = bcd[i] + 4'd1;
          carry      = 1'b0;
        end
      end
    end
  end

  // Burst datapath: each bit is held for BIT_DIV cycles, the LFSR advances at the end of every bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr    <= LFSR_SEED;
      div_cnt <= '0;
      bit_cnt <= '0;
      pin_1   <= 1'b0;
      marker  <= 1'b0;
      bcd     <= '0;
    end else if (launch) begin
      pin_1   <= lfsr[0];
      marker  <= 1'b1;
      div_cnt <= '0;
      bit_cnt <= '0;
    end else if (state == BURST) begin
      if (bit_end) begin
        lfsr    <= lfsr_next;
        div_cnt <= '0;
        if (finish) begin
          pin_1  <= 1'b0;
          marker <= 1'b0;
          bcd    <= bcd_inc;
        end else begin
          bit_cnt <= bit_cnt + LEN_W'(1);
          pin_1   <= lfsr_next[0];
        end
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      HEX0 <= SEG_ZERO;
      HEX1 <= SEG_ZERO;
      HEX2 <= SEG_ZERO;
      HEX3 <= SEG_ZERO;
    end else begin
      HEX0 <= seg7(bcd[0]);
      HEX1 <= seg7(bcd[1]);
      HEX2 <= seg7(bcd[2]);
      HEX3 <= seg7(bcd[3]);
    end
  end

`ifdef DIFF_OUT_EN
  // Differential pair: pin_2 mirrors the inverted noise only while a burst is active.
  assign pin_2 = marker & ~pin_1;
`else
  assign pin_2 = marker;
`endif

endmodule

// File: tb/tb_noise_test_top.sv
// Directed self-checking bench for noise_test_top: burst timing, bit sequence, start handling,
// mid-burst reset, BCD wrap (on a fast-parameter second instance) and the DIFF_OUT_EN pin pair.
module tb_noise_test_top;

  localparam int BD = 5;
  localparam int BL = 32;
  localparam int NB = BD * BL;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S9 = 7'b0010000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic start_f = 1'b0;
  logic pin_1, pin_2, f_pin_1, f_pin_2;
  logic [6:0] hex0, hex1, hex2, hex3;
  logic [6:0] f_hex0, f_hex1, f_hex2, f_hex3;
  logic window;

  int checks = 0;
  int errors = 0;
  logic [15:0] model;
  logic bits [0:1023];
  int len, lat, highs;

  noise_test_top #(.BIT_DIV(BD), .BURST_LEN(BL), .LFSR_SEED(SEED)) dut (
    .clk(clk), .reset(reset), .start(start), .pin_1(pin_1), .pin_2(pin_2),
    .HEX0(hex0), .HEX1(hex1), .HEX2(hex2), .HEX3(hex3)
  );

  noise_test_top #(.BIT_DIV(1), .BURST_LEN(1), .LFSR_SEED(SEED)) dut_fast (
    .clk(clk), .reset(reset), .start(start_f), .pin_1(f_pin_1), .pin_2(f_pin_2),
    .HEX0(f_hex0), .HEX1(f_hex1), .HEX2(f_hex2), .HEX3(f_hex3)
  );

  always #10 clk = ~clk;

`ifdef DIFF_OUT_EN
  assign window = pin_1 | pin_2;
`else
  assign window = pin_2;
`endif

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [15:0] step(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    start_f = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model = SEED;
  endtask

  task automatic check_hex(input string tag, input logic [6:0] e3, e2, e1, e0);
    check({tag, "_hex0"}, {9'd0, hex0}, {9'd0, e0});
    check({tag, "_hex1"}, {9'd0, hex1}, {9'd0, e1});
    check({tag, "_hex2"}, {9'd0, hex2}, {9'd0, e2});
    check({tag, "_hex3"}, {9'd0, hex3}, {9'd0, e3});
  endtask

  // Raise start at a negedge; drop it after one cycle when drop is set. Waits for the burst window.
  task automatic launch_burst(input string tag, input bit drop);
    @(negedge clk);
    start = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (drop && lat == 1) start = 1'b0;
    end while (!window && lat < 50);
    check({tag, "_latency"}, 16'(lat), 16'd3);
  endtask

  // Samples the burst once per cycle; optionally pulses start mid-burst at sample inject_at.
  task automatic capture_burst(input string tag, input int inject_at);
    len = 0;
    while (window && len < 1000) begin
      bits[len] = pin_1;
`ifdef DIFF_OUT_EN
      check({tag, "_diff"}, {15'd0, pin_2}, {15'd0, ~pin_1});
`endif
      if (len == inject_at) start = 1'b1;
      if (len == inject_at + 1) start = 1'b0;
      len++;
      @(negedge clk);
    end
    check({tag, "_length"}, 16'(len), 16'(NB));
    check({tag, "_idle_p1"}, {15'd0, pin_1}, 16'd0);
    check({tag, "_idle_p2"}, {15'd0, pin_2}, 16'd0);
    for (int i = 0; i < NB; i++) begin
      check({tag, "_bit"}, {15'd0, bits[i]}, {15'd0, model[0]});
      if (i % BD == BD - 1) model = step(model);
    end
  endtask

  task automatic check_first_six(input string tag);
    logic [5:0] hand;
    hand = 6'b100001;
    for (int k = 0; k < 6; k++)
      check({tag, "_hand_bit"}, {15'd0, bits[k * BD + 2]}, {15'd0, hand[5 - k]});
  endtask

  task automatic check_quiet(input string tag, input int cycles);
    highs = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (window || pin_1) highs++;
    end
    check({tag, "_quiet"}, 16'(highs), 16'd0);
  endtask

  task automatic pulse_fast();
    @(negedge clk);
    start_f = 1'b1;
    @(negedge clk);
    start_f = 1'b0;
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    model = SEED;
    repeat (3) @(negedge clk);
    check("rst_p1", {15'd0, pin_1}, 16'd0);
    check("rst_p2", {15'd0, pin_2}, 16'd0);
    check_hex("rst", S0, S0, S0, S0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("hold_p1", {15'd0, pin_1}, 16'd0);
    check("hold_p2", {15'd0, pin_2}, 16'd0);

    // Single short pulse
    launch_burst("b1", 1'b1);
    capture_burst("b1", -1);
    check_first_six("b1");
    repeat (2) @(negedge clk);
    check_hex("b1", S0, S0, S0, S1);

    // Start edge inside the burst is ignored
    launch_burst("b2", 1'b1);
    capture_burst("b2", 50);
    check_quiet("b2", 300);
    check_hex("b2", S0, S0, S0, S2);

    // Start held high gives one burst; a new rising edge gives the second
    do_reset();
    launch_burst("held", 1'b0);
    capture_burst("held", -1);
    check_first_six("held");
    check_quiet("held", 500);
    start = 1'b0;
    repeat (5) @(negedge clk);
    launch_burst("held2", 1'b1);
    capture_burst("held2", -1);
    repeat (2) @(negedge clk);
    check_hex("held2", S0, S0, S0, S2);

    // Reset in the middle of a burst
    do_reset();
    launch_burst("abort", 1'b1);
    repeat (40) @(negedge clk);
    #5;
    reset = 1'b1;
    #1;
    check("abort_p1", {15'd0, pin_1}, 16'd0);
    check("abort_p2", {15'd0, pin_2}, 16'd0);
    check_hex("abort", S0, S0, S0, S0);
    @(negedge clk);
    reset = 1'b0;
    model = SEED;
    launch_burst("after", 1'b1);
    capture_burst("after", -1);
    check_first_six("after");
    repeat (2) @(negedge clk);
    check_hex("after", S0, S0, S0, S1);

    // Count carry and 9999 wrap on the fast instance
    do_reset();
    for (int i = 1; i <= 9999; i++) begin
      pulse_fast();
      if (i == 10) begin
        repeat (6) @(negedge clk);
        check("f10_hex0", {9'd0, f_hex0}, {9'd0, S0});
        check("f10_hex1", {9'd0, f_hex1}, {9'd0, S1});
        check("f10_hex2", {9'd0, f_hex2}, {9'd0, S0});
      end
    end
    repeat (6) @(negedge clk);
    check("f9999_hex0", {9'd0, f_hex0}, {9'd0, S9});
    check("f9999_hex1", {9'd0, f_hex1}, {9'd0, S9});
    check("f9999_hex2", {9'd0, f_hex2}, {9'd0, S9});
    check("f9999_hex3", {9'd0, f_hex3}, {9'd0, S9});
    pulse_fast();
    repeat (6) @(negedge clk);
    check("fwrap_hex0", {9'd0, f_hex0}, {9'd0, S0});
    check("fwrap_hex1", {9'd0, f_hex1}, {9'd0, S0});
    check("fwrap_hex2", {9'd0, f_hex2}, {9'd0, S0});
    check("fwrap_hex3", {9'd0, f_hex3}, {9'd0, S0});
    check("fwrap_p2", {15'd0, f_pin_2}, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
